// File: rtl/serial_magnitude_comparator.sv
// Wide unsigned compare walked MSB-first in 2-bit slices, one per clock, exiting on the first unequal slice;
// latency 1..NSLICE compare cycles after accept; one compare in flight, result held in DONE until out_ready.
module comparator_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);
    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);
endmodule

module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic [CNT_W-1:0] slices_used
);
    localparam int NSLICE = WIDTH / 2;

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic             r_out_vld;

    logic [1:0] w_sa;
    logic [1:0] w_sb;
    logic       w_gt;
    logic       w_eq;
    logic       w_lt;

    always_comb begin
        w_sa = 2'b00;
        w_sb = 2'b00;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == CNT_W'(s)) begin
                w_sa = r_a[2*s +: 2];
                w_sb = r_b[2*s +: 2];
            end
        end
    end

    comparator_2bit u_cmp (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= CNT_W'(NSLICE - 1);
                        r_cnt   <= '0;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_gt) begin
                        r_gt      <= 1'b1;
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (w_lt) begin
                        r_lt      <= 1'b1;
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_idx == '0) begin
                        // all slices equal down to the LSB slice
                        r_eq      <= w_eq;
                        r_out_vld <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx <= r_idx - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_gt      <= 1'b0;
                        r_eq      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_out_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign out_valid   = r_out_vld;
    assign a_gt_b      = r_gt;
    assign a_eq_b      = r_eq;
    assign a_lt_b      = r_lt;
    assign slices_used = r_cnt;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator at WIDTH=8: directed vectors with literal expectations,
// plus an arithmetic reference model checked against the outputs on every cycle.
module tb_serial_magnitude_comparator;
    localparam int W  = 8;
    localparam int NS = W / 2;
    localparam int CW = $clog2(NS) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic          gt;
    logic          eq;
    logic          lt;
    logic [CW-1:0] su;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acc   = 0;
    int n_res = 0;

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_gt_b      (gt),
        .a_eq_b      (eq),
        .a_lt_b      (lt),
        .slices_used (su)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Flags from plain unsigned compare; slices examined from the highest differing bit.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  output logic [2:0] f, output int k);
        logic [W-1:0] d;
        int hi;
        d  = ma ^ mb;
        hi = 0;
        for (int i = 0; i < W; i++) if (d[i]) hi = i;
        k = (d == '0) ? NS : NS - hi / 2;
        f = {ma > mb, ma == mb, ma < mb};
    endfunction

    bit         pend = 1'b0;
    logic [2:0] ef;
    int         ek;
    int         eat;

    always @(negedge clk) begin
        bit eov;
        eov = pend && (cyc >= eat);
        chk("in_ready", 32'(in_ready), 32'(!rst && !pend));
        chk("out_valid", 32'(out_valid), 32'(eov));
        if (eov) begin
            chk("flags", 32'({gt, eq, lt}), 32'(ef));
            chk("slices_used", 32'(su), 32'(ek));
        end else begin
            chk("flags_idle", 32'({gt, eq, lt}), 32'd0);
        end
        if (rst) begin
            pend = 1'b0;
        end else if (eov && out_ready) begin
            pend = 1'b0;
            n_res++;
        end else if (!pend && in_valid) begin
            model(a, b, ef, ek);
            eat  = cyc + 1 + ek;
            pend = 1'b1;
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit glitch);
        int t;
        a = ta;
        b = tb;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        if (glitch) begin
            in_valid = 1'b1;
            a = 8'hFF;
            b = 8'h00;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_res(input logic [2:0] xf, input int xk, input int xlat, input int hold);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("latency", 32'(cyc - acc + 1), 32'(xlat));
        chk("dir_flags", 32'({gt, eq, lt}), 32'(xf));
        chk("dir_slices", 32'(su), 32'(xk));
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk("held_valid", 32'(out_valid), 32'd1);
            chk("held_flags", 32'({gt, eq, lt}), 32'(xf));
            chk("held_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] mf;
        int         mk;
        int         n0;
        int         t;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;

        model(8'hC5, 8'h35, mf, mk);
        chk("model_c5_35", 32'({mf, 4'(mk)}), 32'({3'b100, 4'd1}));
        model(8'h12, 8'h13, mf, mk);
        chk("model_12_13", 32'({mf, 4'(mk)}), 32'({3'b001, 4'd4}));
        model(8'h5A, 8'h5A, mf, mk);
        chk("model_5a_5a", 32'({mf, 4'(mk)}), 32'({3'b010, 4'd4}));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags", 32'({gt, eq, lt}), 32'd0);
        chk("rst_slices", 32'(su), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(8'hC5, 8'h35, 1'b0); wait_res(3'b100, 1, 2, 0);
        send(8'h5A, 8'h5A, 1'b0); wait_res(3'b010, 4, 5, 0);
        send(8'h00, 8'h00, 1'b0); wait_res(3'b010, 4, 5, 0);
        send(8'hFF, 8'hFF, 1'b0); wait_res(3'b010, 4, 5, 0);
        send(8'h12, 8'h13, 1'b0); wait_res(3'b001, 4, 5, 0);
        send(8'h13, 8'h12, 1'b0); wait_res(3'b100, 4, 5, 0);
        send(8'h80, 8'h7F, 1'b0); wait_res(3'b100, 1, 2, 3);
        send(8'h30, 8'h31, 1'b1); wait_res(3'b001, 4, 5, 0);
        repeat (4) @(posedge clk);
        #1;

        // reset lands during the second compare cycle
        send(8'h55, 8'h56, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", 32'({gt, eq, lt}), 32'd0);
        chk("midrst_slices", 32'(su), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        send(8'h55, 8'h56, 1'b0); wait_res(3'b001, 4, 5, 0);

        n0 = n_res;
        t  = 0;
        while ((n_res - n0) < 1000 && t < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            @(posedge clk);
            #1;
            t++;
        end
        chk("random_results", 32'((n_res - n0) >= 1000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
